// File: rtl/inv_sched_pkg.sv
// rtl/inv_sched_pkg.sv - shared types and width helpers for the inverter scheduler
package inv_sched_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 16;

  // Requester ID width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  int idx;

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !any && req[idx]) begin
        gnt[idx] = 1'b1;
        id       = ID_W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inv_share_sched.sv
// rtl/inv_share_sched.sv - round-robin sharing of one inverter with a one-entry result buffer
module inv_share_sched
  import inv_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 4,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_flat,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       y,
  output logic [ID_W-1:0]        y_id,
  output logic                   y_valid,
  input  logic                   out_ready
);

  buf_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [ID_W-1:0]  y_id_q, y_id_d;

  logic             en;
  logic             pick_any;
  logic [ID_W-1:0]  pick_id;
  logic [WIDTH-1:0] sel_op;

  // Gating with reset_n keeps gnt quiet while the block is held in reset.
  assign en = reset_n && ((state_q == EMPTY) || out_ready);

  rr_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req(req),
    .ptr(ptr_q),
    .en (en),
    .gnt(gnt),
    .id (pick_id),
    .any(pick_any)
  );

  // One-hot OR mux: lanes that are not granted never reach the inverter.
  always_comb begin
    sel_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_op = sel_op | a_flat[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    y_id_d  = y_id_q;
    if (pick_any) begin
      state_d = FULL;
      y_d     = ~sel_op;
      y_id_d  = pick_id;
      ptr_d   = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      y_q     <= '0;
      y_id_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      y_id_q  <= y_id_d;
    end
  end

  assign y       = y_q;
  assign y_id    = y_id_q;
  assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_inv_share_sched.sv
// tb/tb_inv_share_sched.sv - directed and randomized checks against a behavioural scheduler model
module tb_inv_share_sched;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_flat;
  logic [N-1:0]   gnt;
  logic [W-1:0]   y;
  logic [1:0]     y_id;
  logic           y_valid;
  logic           out_ready;

  int n_checks = 0;
  int n_errors = 0;

  bit             m_valid;
  logic [W-1:0]   m_y;
  int             m_id;
  int             m_ptr;
  int             last_g;

  inv_share_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .a_flat   (a_flat),
    .gnt      (gnt),
    .y        (y),
    .y_id     (y_id),
    .y_valid  (y_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner is the requester at the smallest cyclic distance from the pointer.
  function automatic int pick(input logic [N-1:0] r, input bit en, input int p);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        d = (i - p + N) % N;
        if (r[i] && d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [W-1:0] lane(input logic [N*W-1:0] a, input int i);
    return a[i*W +: W];
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_y     = '0;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  task automatic cycle();
    int g;
    bit en;
    @(negedge clk);
    en = !m_valid || out_ready;
    g  = pick(req, en, m_ptr);
    check("gnt", {28'd0, gnt}, (g < 0) ? 32'd0 : (32'd1 << g));
    check("y_valid", {31'd0, y_valid}, {31'd0, m_valid});
    check("y", {28'd0, y}, {28'd0, m_y});
    check("y_id", {30'd0, y_id}, m_id);
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1;
      m_y     = ~lane(a_flat, g);
      m_id    = g;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    last_g = g;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("rst_y", {28'd0, y}, 32'd0);
    check("rst_y_id", {30'd0, y_id}, 32'd0);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    req       = '0;
    a_flat    = '0;
    out_ready = 1'b0;
    last_g    = -1;
    #1;
    do_reset();

    // 1: single request, first result one cycle later
    req = 4'b0001; a_flat = '0; out_ready = 1'b1;
    cycle();
    check("t1_y", {28'd0, y}, 32'hF);
    check("t1_valid", {31'd0, y_valid}, 32'd1);

    // 2: all requesting, strict rotation and one result per cycle
    do_reset();
    req = 4'b1111; a_flat = {4'h3, 4'h2, 4'h1, 4'h0}; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t2_y", {28'd0, y}, 32'(15 - (k % 4)));
      check("t2_id", {30'd0, y_id}, 32'(k % 4));
    end

    // 3: backpressure holds the buffered result and blocks grants
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t3_hold_y", {28'd0, y}, 32'hF);
      check("t3_hold_id", {30'd0, y_id}, 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    check("t3_reload_id", {30'd0, y_id}, 32'd1);

    // 4: pointer at 2 wraps to requester 0
    req = 4'b0011;
    cycle();
    check("t4_wrap_id", {30'd0, y_id}, 32'd0);
    req = 4'b0010;
    cycle();
    check("t4_next_id", {30'd0, y_id}, 32'd1);

    // 5: reset while full with requests active
    req = 4'b1111;
    do_reset();
    req = 4'b1010;
    cycle();
    check("t5_first_id", {30'd0, y_id}, 32'd1);

    // 6: requester 3 withdraws before being served
    req = 4'b1000; out_ready = 1'b0;
    cycle();
    req = 4'b0001; out_ready = 1'b1;
    cycle();
    check("t6_id", {30'd0, y_id}, 32'd0);
    req = 4'b0000;
    cycle();
    check("t6_drain", {31'd0, y_valid}, 32'd0);

    // Randomized traffic obeying the requester hold rules
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_g == i) begin
          req[i]          = ($urandom_range(0, 1) == 1);
          a_flat[i*W +: W] = W'($urandom);
        end else if ($urandom_range(0, 9) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        last_g = -1;
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
